// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter driving the mux2to1 select; registered grants and select.
// Optional dwell-limit preemption under contention is enabled by defining MUX_SEL_PREEMPT_EN.
module mux_sel_arbiter #(
  parameter int DWELL_W   = 4,
  parameter int MAX_DWELL = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req_x,
  input  logic req_y,
  output logic gnt_x,
  output logic gnt_y,
  output logic s,
  output logic busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, GX = 2'd1, GY = 2'd2} state_e;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(MAX_DWELL - 1);

  state_e             state_q, state_d;
  logic               last_q, last_d;   // 0 = X won last, 1 = Y won last
  logic               s_q, s_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               preempt_en;
  logic               dwell_hit;

`ifdef MUX_SEL_PREEMPT_EN
  assign preempt_en = 1'b1;
`else
  assign preempt_en = 1'b0;
`endif

  assign dwell_hit = (cnt_q == DWELL_LAST);

  function automatic state_e arbitrate(input logic rx, input logic ry, input logic lst);
    if (rx && ry) return lst ? GX : GY;
    if (rx)       return GX;
    if (ry)       return GY;
    return IDLE;
  endfunction

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = arbitrate(req_x, req_y, last_q);
      GX: begin
        if (!req_x)                                 state_d = arbitrate(1'b0, req_y, 1'b0);
        else if (preempt_en && req_y && dwell_hit)  state_d = GY;
      end
      GY: begin
        if (!req_y)                                 state_d = arbitrate(req_x, 1'b0, 1'b1);
        else if (preempt_en && req_x && dwell_hit)  state_d = GX;
      end
      default: state_d = IDLE;
    endcase
    // Grant entry: restart dwell, record winner, steer the mux.
    if (state_d != IDLE && state_d != state_q) begin
      cnt_d  = '0;
      last_d = (state_d == GY);
      s_d    = (state_d == GY);
    end else if (state_q != IDLE && state_d == state_q && cnt_q != '1) begin
      cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      s_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_x = (state_q == GX);
  assign gnt_y = (state_q == GY);
  assign s     = s_q;
  assign busy  = gnt_x | gnt_y;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: directed vector table, dwell sequence, random run vs reference model.
module tb_mux_sel_arbiter;

  localparam int MAXD = 4;

  logic clk = 1'b0;
  logic reset, req_x, req_y;
  logic gnt_x, gnt_y, s, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner 0 = none, 1 = X, 2 = Y.
  int m_owner, m_last, m_s, m_held;

  mux_sel_arbiter #(.DWELL_W(4), .MAX_DWELL(MAXD)) dut (
    .clk(clk), .reset(reset), .req_x(req_x), .req_y(req_y),
    .gnt_x(gnt_x), .gnt_y(gnt_y), .s(s), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit rx, input bit ry);
    int nxt;
    bit preempt;
    if (r) begin
      m_owner = 0; m_last = 2; m_s = 0; m_held = 0;
      return;
    end
    preempt = 1'b0;
`ifdef MUX_SEL_PREEMPT_EN
    preempt = rx && ry && (m_owner != 0) && (m_held == MAXD - 1);
`endif
    nxt = m_owner;
    if (preempt) nxt = (m_owner == 1) ? 2 : 1;
    else if (m_owner == 0 || (m_owner == 1 && !rx) || (m_owner == 2 && !ry)) begin
      if (rx && ry)  nxt = (m_last == 1) ? 2 : 1;
      else if (rx)   nxt = 1;
      else if (ry)   nxt = 2;
      else           nxt = 0;
    end
    if (nxt != 0 && nxt != m_owner) begin
      m_last = nxt; m_held = 0; m_s = (nxt == 2) ? 1 : 0;
    end else if (nxt != 0 && m_held < 15) begin
      m_held++;
    end
    m_owner = nxt;
  endtask

  task automatic step(input bit r, input bit rx, input bit ry);
    reset = r; req_x = rx; req_y = ry;
    @(posedge clk);
    model_step(r, rx, ry);
    #1;
    chk("model_gnt_x", int'(gnt_x), int'(m_owner == 1));
    chk("model_gnt_y", int'(gnt_y), int'(m_owner == 2));
    chk("model_s",     int'(s),     m_s);
    chk("model_busy",  int'(busy),  int'(m_owner != 0));
    @(negedge clk);
  endtask

  typedef struct {
    bit r; bit rx; bit ry;
    bit gx; bit gy; bit s;
  } vec_t;

  vec_t tbl[23];

  initial begin
    int gx_cnt;
    int exp_cnt;
    tbl[0]  = '{1, 0, 0, 0, 0, 0};  // reset
    tbl[1]  = '{0, 1, 0, 1, 0, 0};  // X alone, 3 cycles
    tbl[2]  = '{0, 1, 0, 1, 0, 0};
    tbl[3]  = '{0, 1, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0};  // release, s parks at 0
    tbl[5]  = '{1, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 1, 1, 0, 0};  // first tie goes to X
    tbl[7]  = '{0, 0, 1, 0, 1, 1};  // zero-bubble handoff
    tbl[8]  = '{0, 0, 1, 0, 1, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 1};  // idle, s parked at Y
    tbl[10] = '{0, 1, 1, 1, 0, 0};  // alternation
    tbl[11] = '{0, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 1, 0, 1, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 1};
    tbl[14] = '{0, 1, 1, 1, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0};
    tbl[16] = '{0, 1, 1, 0, 1, 1};
    tbl[17] = '{1, 1, 1, 0, 0, 0};  // reset mid-GY wins over requests
    tbl[18] = '{0, 1, 1, 1, 0, 0};  // last back to Y: X wins
    tbl[19] = '{0, 1, 1, 1, 0, 0};  // Y request withdrawn before grant
    tbl[20] = '{0, 1, 0, 1, 0, 0};
    tbl[21] = '{0, 1, 0, 1, 0, 0};
    tbl[22] = '{0, 0, 0, 0, 0, 0};

    reset = 1'b1; req_x = 1'b0; req_y = 1'b0;
    m_owner = 0; m_last = 2; m_s = 0; m_held = 0;
    @(negedge clk);

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].r, tbl[i].rx, tbl[i].ry);
      chk($sformatf("vec%0d_gnt_x", i), int'(gnt_x), int'(tbl[i].gx));
      chk($sformatf("vec%0d_gnt_y", i), int'(gnt_y), int'(tbl[i].gy));
      chk($sformatf("vec%0d_s", i),     int'(s),     int'(tbl[i].s));
      chk($sformatf("vec%0d_busy", i),  int'(busy),  int'(tbl[i].gx | tbl[i].gy));
    end

    // Dwell: X holds, Y requests from grant cycle 0.
    step(1, 0, 0);
    step(0, 1, 0);
    chk("dwell_start_gnt_x", int'(gnt_x), 1);
    gx_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1);
      if (gnt_x) gx_cnt++;
    end
`ifdef MUX_SEL_PREEMPT_EN
    exp_cnt = MAXD - 1;
    chk("dwell_end_gnt_y", int'(gnt_y), 1);
    chk("dwell_end_s",     int'(s),     1);
`else
    exp_cnt = 6;
    chk("dwell_end_gnt_x", int'(gnt_x), 1);
    chk("dwell_end_s",     int'(s),     0);
`endif
    chk("dwell_gnt_x_cycles", gx_cnt, exp_cnt);

    // Random traffic with occasional reset.
    step(1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Synchronous two-requester round-robin arbiter that generates the select line `s` for the `mux2to1` datapath stage directly downstream. Source X owns the mux (`s`=0, `m`=`x`) or source Y owns it (`s`=1, `m`=`y`). Grants follow a request/grant handshake with fair alternation under contention. An optional dwell limit preempts a source that holds the mux too long while the other source waits.

## Interface
Parameters:
- `DWELL_W`, default 4: width of the dwell counter.
- `MAX_DWELL`, default 8: maximum grant length in cycles under contention. Legal range 1 .. 2^`DWELL_W`-1. Used only when the feature in Configuration is compiled in.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req_x`  input  1  source X requests the mux.
- `req_y`  input  1  source Y requests the mux.
- `gnt_x`  output  1  X owns the mux; registered.
- `gnt_y`  output  1  Y owns the mux; registered.
- `s`  output  1  mux select, 0 = X, 1 = Y; registered. Drives `mux2to1.s`.
- `busy`  output  1  `gnt_x | gnt_y`.

## Operation
- States are IDLE, GX and GY. `gnt_x`=1 only in GX and `gnt_y`=1 only in GY. They are never both 1.
- A `last` register records the most recent winner.
- Arbitration decision, used from IDLE and on any release:
  - Both requesting: grant the source that is not `last`.
  - One requesting: grant that source.
  - None requesting: go to IDLE.
- IDLE: apply the arbitration decision.
- GX: hold while `req_x`=1, unless preempted (see Configuration). When `req_x`=0, apply the arbitration decision with `last`=X. This gives zero-bubble handoff to Y if `req_y`=1.
- GY: symmetric to GX.
- `s` update rules:
  - Entering GX sets `s`=0.
  - Entering GY sets `s`=1.
  - In IDLE, `s` holds its previous value (parks on last owner).
- `last` updates on every grant entry.
- Dwell counter:
  - Clears to 0 on every grant entry.
  - Increments each cycle the grant is held.
  - Saturates at 2^`DWELL_W`-1.
- Requests are level-sensitive. A requester must hold its request until granted. Dropping the request before the grant withdraws it with no side effect.

## Timing
- Reset values: state=IDLE, `gnt_x`=0, `gnt_y`=0, `s`=0, `busy`=0, `last`=Y (so X wins the first tie), counter=0.
- Grant latency: a request sampled at edge N with the arbiter free produces the grant after edge N, i.e. visible in cycle N+1.
- Release latency: the request sampled low at edge N causes the grant to drop after edge N. The same edge may raise the other grant.
- `s` changes on the same edge as the grant. The downstream mux is combinational, so `m` follows in that cycle.
- Simultaneous first requests out of reset: X granted.
- Reset mid-grant: the next edge forces all reset values, regardless of requests. `last` returns to Y.
- Both requests deasserted while in GX/GY: the next edge goes to IDLE, and `s` is held.

## Configuration
- Macro `MUX_SEL_PREEMPT_EN`.
- Defined:
  - In GX, if `req_y`=1 and the counter = `MAX_DWELL`-1, the next edge moves to GY (counter clears, `last`=Y), even if `req_x` is still 1.
  - GY is symmetric.
  - A preempted source keeps requesting and regains the mux by round-robin.
  - Without contention, no preemption occurs.
- Undefined:
  - No preemption. A grant is held until its request drops.
  - The counter remains but has no functional effect.

## Test plan
- Reset, then `req_x`=1 for 3 cycles: `gnt_x`=1 and `s`=0 from cycle 1 to 3. Grant drops one edge after `req_x` falls, and `s` stays 0.
- `req_x`=`req_y`=1 in the same cycle after reset: X granted first. When `req_x` drops, `gnt_y`=1 and `s`=1 on that same edge with no idle cycle.
- Alternating contention with both requesters dropping after each grant: grants alternate X, Y, X, Y, and `last` toggles each time.
- With `MUX_SEL_PREEMPT_EN` and `MAX_DWELL`=4, `req_x` held high, `req_y` asserted at grant cycle 0: `gnt_x` lasts exactly 4 cycles, then `gnt_y`=1 and `s`=1. Without the macro, `gnt_x` persists indefinitely.
- `reset` asserted while in GY with `s`=1: after the next edge, `gnt_y`=0, `s`=0 and `busy`=0. A subsequent simultaneous request grants X.
- `req_y` pulsed for 1 cycle while X is granted, then dropped: no grant to Y, and X is unaffected.
